// File: rtl/mult32x32_ctrl.sv
// Control sequencer for the 32x32 arithmetic unit (mult32x32_arith).
// Latches A/B on start, then walks the eight byte(A) x halfword(B) partial products
// with Moore-decoded select/update/clear controls, and pulses done when the product is final.
// Optional feature: define MULT_SKIP_ZERO_EN to skip steps whose partial product is zero.
module mult32x32_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] a_op,
  output logic [31:0] b_op,
  output logic [1:0]  a_sel,
  output logic        b_sel,
  output logic [2:0]  shift_sel,
  output logic        upd_prod,
  output logic        clr_prod
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StClr  = 2'd1;
  localparam logic [1:0] StStep = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] a_op_q, a_op_d;
  logic [31:0] b_op_q, b_op_d;

`ifdef MULT_SKIP_ZERO_EN
  logic [7:0] nz;
  logic       nxt_found;
  logic [2:0] nxt_k;

  // Mark the step indices whose byte/halfword pair are both non-zero.
  always_comb begin
    nz = '0;
    for (int i = 0; i < 8; i++) begin
      nz[i] = (a_op_q[8*(i%4) +: 8] != 8'd0) && (b_op_q[16*(i/4) +: 16] != 16'd0);
    end
  end

  // Find the lowest useful index: any index from CLR, strictly above k from STEP.
  always_comb begin
    nxt_found = 1'b0;
    nxt_k     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (nz[i] && ((state_q == StClr) || (i > int'(k_q)))) begin
        nxt_found = 1'b1;
        nxt_k     = 3'(i);
      end
    end
  end
`endif

  // Next-state logic for the sequencer and the operand latches.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_op_d  = a_op_q;
    b_op_d  = b_op_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_op_d  = a;
          b_op_d  = b;
          state_d = StClr;
        end
      end
      StClr: begin
`ifdef MULT_SKIP_ZERO_EN
        k_d     = nxt_k;
        state_d = nxt_found ? StStep : StDone;
`else
        k_d     = 3'd0;
        state_d = StStep;
`endif
      end
      StStep: begin
`ifdef MULT_SKIP_ZERO_EN
        if (nxt_found) begin
          k_d = nxt_k;
        end else begin
          state_d = StDone;
        end
`else
        if (k_q == 3'd7) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 3'd1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
        k_d     = 3'd0;
      end
      default: begin
        state_d = StIdle;
        k_d     = 3'd0;
      end
    endcase
  end

  // State, step counter and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= 3'd0;
      a_op_q  <= 32'd0;
      b_op_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
    end
  end

  // Moore output decode; selects are forced to zero outside STEP.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    clr_prod  = (state_q == StClr);
    upd_prod  = (state_q == StStep);
    a_sel     = 2'd0;
    b_sel     = 1'b0;
    shift_sel = 3'd0;
    if (state_q == StStep) begin
      a_sel     = k_q[1:0];
      b_sel     = k_q[2];
      // Byte offset of the partial product: A byte + 2 * B half, range 0..5.
      shift_sel = {1'b0, k_q[1:0]} + {1'b0, k_q[2], 1'b0};
    end
  end

  assign a_op = a_op_q;
  assign b_op = b_op_q;

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Scoreboard bench for mult32x32_ctrl. A reference model decides when jobs are accepted and
// pushes the expected job into a queue; a negedge monitor checks the controls cycle by cycle,
// accumulates the product the way the arith unit would, and compares it at done.
module tb_mult32x32_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] a_op, b_op;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [2:0]  shift_sel;
  logic        upd_prod, clr_prod;

  mult32x32_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .a_op      (a_op),
    .b_op      (b_op),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .shift_sel (shift_sel),
    .upd_prod  (upd_prod),
    .clr_prod  (clr_prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          e;
    logic [7:0]  mask;
    int          n;
  } job_t;

  job_t        jobs[$];
  int          cyc      = 0;
  int          free_at  = 0;
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] acc      = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Indices k (A byte k%4, B half k/4) that the sequencer is expected to visit.
  function automatic logic [7:0] job_mask(input logic [31:0] av, input logic [31:0] bv);
    logic [7:0] m;
    m = 8'hFF;
`ifdef MULT_SKIP_ZERO_EN
    for (int i = 0; i < 8; i++) begin
      m[i] = (((av >> (8 * (i % 4))) & 32'hFF) != 0) && (((bv >> (16 * (i / 4))) & 32'hFFFF) != 0);
    end
`endif
    return m;
  endfunction

  function automatic int nth_bit(input logic [7:0] m, input int n);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (c == n) return i;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic logic [31:0] sparse();
    logic [31:0] v;
    logic [3:0]  keep;
    v    = $urandom;
    keep = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (!keep[i]) v[8*i +: 8] = 8'h00;
    end
    return v;
  endfunction

  // Reference model: a start seen at edge cyc is accepted once the previous job has fully drained.
  initial begin : model
    job_t nj;
    forever begin
      @(posedge clk);
      if (!reset && start && cyc >= free_at) begin
        nj.a    = a;
        nj.b    = b;
        nj.prod = 64'(a) * 64'(b);
        nj.e    = cyc;
        nj.mask = job_mask(a, b);
        nj.n    = $countones(nj.mask);
        jobs.push_back(nj);
        free_at = cyc + nj.n + 3;
      end
      cyc++;
    end
  end

  // Monitor: at each negedge cyc equals the spec's cycle number relative to edge 0.
  initial begin : monitor
    job_t j;
    bit   act, e_clr, e_upd, e_done;
    int   idx, kk;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 0; e_clr = 0; e_upd = 0; e_done = 0; kk = 0; idx = 0;
        if (jobs.size() > 0) begin
          j      = jobs[0];
          act    = (cyc >= j.e + 1) && (cyc <= j.e + 2 + j.n);
          idx    = cyc - j.e - 2;
          e_clr  = act && (cyc == j.e + 1);
          e_upd  = act && (idx >= 0) && (idx < j.n);
          e_done = act && (cyc == j.e + 2 + j.n);
          if (e_upd) kk = nth_bit(j.mask, idx);
        end
        check("busy", 64'(busy), 64'(act));
        check("clr_prod", 64'(clr_prod), 64'(e_clr));
        check("upd_prod", 64'(upd_prod), 64'(e_upd));
        check("done", 64'(done), 64'(e_done));
        check("a_sel", 64'(a_sel), e_upd ? 64'(kk % 4) : 64'd0);
        check("b_sel", 64'(b_sel), e_upd ? 64'(kk / 4) : 64'd0);
        check("shift_sel", 64'(shift_sel), e_upd ? 64'((kk % 4) + 2 * (kk / 4)) : 64'd0);
        if (act) begin
          check("a_op", 64'(a_op), 64'(j.a));
          check("b_op", 64'(b_op), 64'(j.b));
        end
        // Stand-in for the arith unit's product register.
        if (clr_prod) acc = 64'd0;
        if (upd_prod) begin
          acc = acc + ((64'((a_op >> (8 * a_sel)) & 32'hFF) *
                        64'((b_op >> (16 * b_sel)) & 32'hFFFF)) << (8 * shift_sel));
        end
        if (e_done) begin
          check("product", acc, j.prod);
          void'(jobs.pop_front());
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for the scoreboard to empty, scrambling a/b and pulsing start only while busy.
  task automatic drain();
    int n;
    n = 0;
    while (jobs.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
      start = (cyc < free_at) && ($urandom_range(0, 3) == 0);
      a = $urandom;
      b = $urandom;
    end
    start = 1'b0;
    check("drain_timeout", 64'(jobs.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_upd"}, 64'(upd_prod), 64'd0);
    check({tag, "_clr"}, 64'(clr_prod), 64'd0);
    check({tag, "_a_sel"}, 64'(a_sel), 64'd0);
    check({tag, "_b_sel"}, 64'(b_sel), 64'd0);
    check({tag, "_shift"}, 64'(shift_sel), 64'd0);
  endtask

  initial begin : stim
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_a_op", 64'(a_op), 64'd0);
    check("rst_b_op", 64'(b_op), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_job(32'hFFFFFFFF, 32'hFFFFFFFF); drain();
    run_job(32'h00000002, 32'h00030000); drain();
    run_job(32'h00000100, 32'h00000001); drain();
    run_job(32'h00000000, $urandom);     drain();
    run_job($urandom, 32'h00000000);     drain();

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 2))
        0:       begin ra = $urandom; rb = $urandom; end
        1:       begin ra = sparse(); rb = sparse(); end
        default: begin ra = sparse(); rb = $urandom & 32'h0000FFFF; end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_job(ra, rb);
      drain();
    end

    // Start held high: back-to-back jobs with one idle cycle between them.
    @(negedge clk); #1;
    start = 1'b1; a = $urandom; b = $urandom;
    repeat (45) begin
      @(negedge clk); #1;
      a = $urandom; b = $urandom;
    end
    start = 1'b0;
    drain();

    // Reset in cycle 5 of a job, while STEP is at k=3.
    run_job(32'hFFFFFFFF, 32'h12345678);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_a_op", 64'(a_op), 64'd0);
    jobs.delete();
    free_at = 0;
    acc     = 64'd0;
    @(negedge clk); #1;
    reset = 1'b0;
    run_job($urandom, $urandom); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
